// File: rtl/edl_final_pio_in_edge.sv
// rtl/edl_final_pio_in_edge.sv - Avalon-MM input PIO with synchroniser, debounce, edge capture and irq
module edl_final_pio_in_edge #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_MODE        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0]                  stable;
  logic [WIDTH-1:0]                  stable_d;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  edge_vec;
  logic [WIDTH-1:0]                  mask;
  logic [WIDTH-1:0]                  edgecapture;
  logic [WIDTH-1:0]                  ec_clr;
  logic                              wr_en;
  logic                              mask_wr;
  logic [31:0]                       rd_mux;
  logic                              irq_src;
  logic                              unused_wdata;

  // Bits of writedata above WIDTH are don't-care on every register.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable <= '0;
        end else begin
          stable <= sync;
        end
      end
    end else begin : g_debounce
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [WIDTH-1:0][CNT_W-1:0] cnt_q;

      // A bit is accepted only after it has disagreed with stable for
      // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable <= '0;
          cnt_q  <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] != stable[i]) begin
              if (cnt_q[i] == CNT_LAST) begin
                stable[i] <= sync[i];
                cnt_q[i]  <= '0;
              end else begin
                cnt_q[i]  <= cnt_q[i] + 1'b1;
              end
            end else begin
              cnt_q[i] <= '0;
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  always_comb begin
    edge_vec = '0;
    case (EDGE_TYPE)
      0:       edge_vec = rise;
      1:       edge_vec = fall;
      default: edge_vec = rise | fall;
    endcase
  end

  assign wr_en   = chipselect & ~write_n;
  assign mask_wr = wr_en && (address == 2'd2);
  assign ec_clr  = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
    end else if (mask_wr) begin
      mask <= writedata[WIDTH-1:0];
    end
  end

  // A new edge in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~ec_clr) | edge_vec;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd2:    rd_mux[WIDTH-1:0] = mask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq_src = (IRQ_MODE == 0) ? |(stable & mask) : |(edgecapture & mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_src;
    end
  end

endmodule

// File: tb/tb_edl_final_pio_in_edge.sv
// tb/tb_edl_final_pio_in_edge.sv - directed bench over three PIO configurations sharing one bus
module tb_edl_final_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // a: no debounce, any edge, edge irq.  b: 3-stage sync, 8-cycle debounce,
  // rising edge, level irq.  c: single bit, falling edge, edge irq.
  edl_final_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                          .EDGE_TYPE(2), .IRQ_MODE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .irq(irq_a));

  edl_final_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8),
                          .EDGE_TYPE(0), .IRQ_MODE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .irq(irq_b));

  edl_final_pio_in_edge #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                          .EDGE_TYPE(1), .IRQ_MODE(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_c),
    .in_port(in_c), .irq(irq_c));

  typedef struct {
    logic [3:0]  in_val;
    bit          do_wr;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus tasks are entered on a negedge and return on the following negedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; address = 2'd1;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd1; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_a = '0; in_b = '0; in_c = 1'b0;

    //          in    wr  waddr  wdata          raddr  exp_rd         irq
    tbl[0]  = '{4'h0, 0, 2'd0, 32'h0,         2'd0, 32'h0000_0000, 1'b0};
    tbl[1]  = '{4'h0, 0, 2'd0, 32'h0,         2'd2, 32'h0000_0000, 1'b0};
    tbl[2]  = '{4'h0, 0, 2'd0, 32'h0,         2'd3, 32'h0000_0000, 1'b0};
    tbl[3]  = '{4'hA, 0, 2'd0, 32'h0,         2'd0, 32'h0000_000A, 1'b0};
    tbl[4]  = '{4'hA, 0, 2'd0, 32'h0,         2'd3, 32'h0000_000A, 1'b0};
    tbl[5]  = '{4'hA, 1, 2'd2, 32'hFFFF_FFF2, 2'd2, 32'h0000_0002, 1'b1};
    tbl[6]  = '{4'hA, 1, 2'd3, 32'h0000_0002, 2'd3, 32'h0000_0008, 1'b0};
    tbl[7]  = '{4'h8, 0, 2'd0, 32'h0,         2'd3, 32'h0000_000A, 1'b1};
    tbl[8]  = '{4'h8, 1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000, 1'b1};
    tbl[9]  = '{4'h8, 1, 2'd0, 32'h0000_000F, 2'd0, 32'h0000_0008, 1'b1};
    tbl[10] = '{4'h8, 1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000, 1'b0};
    tbl[11] = '{4'h8, 1, 2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000, 1'b0};
    tbl[12] = '{4'h5, 0, 2'd0, 32'h0,         2'd3, 32'h0000_000D, 1'b0};
    tbl[13] = '{4'h5, 1, 2'd2, 32'h0000_0001, 2'd0, 32'h0000_0005, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_rd_a", rd_a, 32'h0);
    chk("reset_rd_b", rd_b, 32'h0);
    chk("reset_irq_a", irq_a, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      in_a = tbl[i].in_val;
      repeat (5) @(negedge clk);
      if (tbl[i].do_wr) begin
        bus_write(tbl[i].wr_addr, tbl[i].wr_data);
        repeat (2) @(negedge clk);
      end
      bus_read(tbl[i].rd_addr);
      chk($sformatf("vec%0d_rd", i), rd_a, tbl[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), irq_a, tbl[i].exp_irq);
    end

    // read latency: exactly one clock from address to readdata
    @(negedge clk);
    address = 2'd0; chipselect = 1'b1; write_n = 1'b1;
    #4;
    chk("lat_before_edge", rd_a, 32'h0);
    @(negedge clk);
    chk("lat_after_edge", rd_a, 32'h5);
    chipselect = 1'b0; address = 2'd1;

    // set/clear collision on bit 2
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h0);
    in_a = 4'h0;
    repeat (6) @(negedge clk);
    bus_write(2'd3, 32'hF);
    @(negedge clk);
    in_a = 4'h4;
    repeat (3) @(negedge clk);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    chk("collide_set_wins", rd_a, 32'h4);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    chk("w1c_bit2", rd_a, 32'h0);
    in_a = 4'h0;
    repeat (6) @(negedge clk);
    bus_write(2'd2, 32'h4);
    repeat (2) @(negedge clk);
    chk("irq_before_reset", irq_a, 1'b1);

    // asynchronous reset mid-debounce
    in_b = 4'h2;
    address = 2'd3;
    repeat (6) @(negedge clk);
    chk("pre_reset_rd", rd_a, 32'h4);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rd", rd_a, 32'h0);
    chk("async_rst_irq", irq_a, 1'b0);
    in_a = 4'h1; in_b = 4'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    address = 2'd1;
    repeat (6) @(negedge clk);
    bus_read(2'd2);
    chk("post_rst_mask", rd_a, 32'h0);
    bus_read(2'd3);
    chk("post_rst_edge", rd_a, 32'h1);
    bus_write(2'd3, 32'h1);
    repeat (10) @(negedge clk);
    bus_read(2'd3);
    chk("post_rst_once", rd_a, 32'h0);

    // debounce: a 7-clock glitch is rejected
    in_b = 4'h1;
    repeat (7) @(negedge clk);
    in_b = 4'h0;
    repeat (20) @(negedge clk);
    bus_read(2'd0);
    chk("glitch_data", rd_b, 32'h0);
    bus_read(2'd3);
    chk("glitch_edge", rd_b, 32'h0);

    // debounce: held input reaches stable after SYNC_STAGES+8 clocks
    address = 2'd0;
    in_b = 4'h1;
    repeat (11) @(negedge clk);
    chk("db_lat_early", rd_b, 32'h0);
    @(negedge clk);
    chk("db_lat", rd_b, 32'h1);
    @(negedge clk);
    bus_read(2'd3);
    chk("db_edge", rd_b, 32'h1);
    bus_write(2'd2, 32'h1);
    repeat (2) @(negedge clk);
    chk("level_irq_on", irq_b, 1'b1);
    bus_write(2'd2, 32'h0);
    repeat (2) @(negedge clk);
    chk("level_irq_off", irq_b, 1'b0);
    bus_write(2'd3, 32'hF);
    in_b = 4'h0;
    repeat (15) @(negedge clk);
    bus_read(2'd3);
    chk("rise_only_no_fall", rd_b, 32'h0);
    bus_read(2'd0);
    chk("db_data_low", rd_b, 32'h0);

    // falling-edge only, single bit
    in_c = 1'b1;
    repeat (6) @(negedge clk);
    bus_read(2'd3);
    chk("fall_only_no_rise", rd_c, 32'h0);
    in_c = 1'b0;
    repeat (6) @(negedge clk);
    bus_read(2'd3);
    chk("fall_captured", rd_c, 32'h1);
    bus_write(2'd2, 32'h1);
    repeat (2) @(negedge clk);
    chk("edge_irq_c_on", irq_c, 1'b1);
    bus_write(2'd3, 32'h1);
    repeat (2) @(negedge clk);
    chk("edge_irq_c_off", irq_c, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
